pedestrian_request_handler: RTL and testbench
=============================================

Name: pedestrian_request_handler

Overview:
Front-end for the pedestrian crossing interface of traffic_light_controller. It synchronises and debounces the raw NS/EW crosswalk buttons and latches each press as a pending request. It holds NS_pedestrian_button/EW_pedestrian_button high until the controller answers with the matching pedestrian signal for long enough, then drives "wait" lamps. It also flags unserved-request timeouts and unsafe walk signals.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive equal synchronised samples needed to change a debounced level (min 1)
TIMEOUT_CYCLES, 64, pending-request age at which the timeout flag sets
SERVE_MIN, 2, consecutive cycles the pedestrian signal must be high for a request to count as served (min 1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
NS_button_raw  in  1  raw NS crosswalk button, asynchronous, bouncy
EW_button_raw  in  1  raw EW crosswalk button
NS_pedestrian_Signal  in  1  walk signal from controller, NS crossing
EW_pedestrian_Signal  in  1  walk signal from controller, EW crossing
NS_direction  in  3  NS traffic light from controller
EW_direction  in  3  EW traffic light from controller
NS_pedestrian_button  out  1  latched NS request to controller
EW_pedestrian_button  out  1  latched EW request to controller
NS_wait_lamp  out  1  NS request pending, not yet served
EW_wait_lamp  out  1  EW request pending, not yet served
NS_timeout  out  1  sticky: NS request pending for at least TIMEOUT_CYCLES
EW_timeout  out  1  sticky: EW request pending for at least TIMEOUT_CYCLES
conflict_err  out  1  sticky: walk signal high while its crossing light is not RED

Behaviour:
- Reset (reset=0, asynchronous) clears all state immediately: every output 0, FSMs in IDLE, counters 0, debounced levels 0. Applies mid-operation; a pending request is lost.
- Light encoding (3 bits): 3'b100 RED, 3'b010 YELLOW, 3'b001 GREEN. Any other value counts as not RED.
- Each raw button passes through a 2-flop synchroniser, then a debouncer.
  - The debouncer counter increments while the synchronised sample differs from the debounced level. It clears when the sample matches.
  - The debounced level flips on the edge the counter reaches DEBOUNCE_CYCLES.
  - Press event = rising edge of the debounced level. It is a 1-cycle pulse.
- Per-channel FSM, identical for NS and EW:
  - IDLE: button=0, wait=0. On a press event, go to REQ and clear the age counter.
  - REQ: button=1, wait=1.
    - Age counter increments each cycle, saturating at TIMEOUT_CYCLES. On reaching it, timeout is set.
    - Pedestrian signal=1: go to SERVE with serve count=1.
    - Further presses are ignored.
  - SERVE: button=1, wait=0.
    - Serve count increments while the signal stays 1. Reaching SERVE_MIN: go to DONE and clear timeout.
    - Signal drops before SERVE_MIN: return to REQ; the age counter is not cleared.
  - DONE: button=0, wait=0. Signal=0: go to IDLE. Presses in DONE are ignored.
- Latency: a raw press held stable gives button=1 DEBOUNCE_CYCLES+3 rising edges after the first edge sampling it high (7 at default).
- Release latency: after the signal rises, button drops SERVE_MIN+1 edges later.
- Simultaneous NS and EW presses are handled independently; both may be pending.
- A press event on the same edge as the signal rising in IDLE goes to REQ; the signal is checked from the next edge.
- conflict_err sets when (NS_pedestrian_Signal=1 and NS_direction≠RED) or (EW_pedestrian_Signal=1 and EW_direction≠RED). Checked every cycle. Cleared only by reset.
- Widths: counters are sized by $clog2(param+1). They saturate and never wrap.

Decomposition:
- Package traffic_pkg:
  - light encoding constants RED/YELLOW/GREEN
  - enum typedef ped_state_t {IDLE, REQ, SERVE, DONE}
  - shared by traffic_light_controller.
- Sub-module ped_channel: synchroniser, debouncer, FSM, age and serve counters, and timeout for one crossing.
  - The top instantiates it twice and adds the conflict_err logic.

Test Plan:
- Reset held 0, buttons toggling → all outputs stay 0. Release reset, no presses for 100 cycles → outputs remain 0.
- NS_button_raw held 1 → NS_pedestrian_button and NS_wait_lamp go to 1 at edge 7.
  - NS_pedestrian_Signal high for 2 cycles → button drops at the 3rd edge.
  - Signal low → state back to IDLE.
- Raw button bouncing 1,0,1,0 on single cycles then 0 → no request. A pulse of 3 stable cycles → no request. A pulse of 4 → request.
- EW request pending with no signal → EW_timeout=1 exactly 64 cycles after entering REQ.
  - Signal high for 1 cycle then low → remains REQ, timeout stays 1.
  - Later 2-cycle serve → timeout clears.
- NS_pedestrian_Signal=1 while NS_direction=3'b001 → conflict_err=1 next edge and stays 1 after the signal drops, until reset.
- Both buttons pressed on the same cycle → both requests assert together. Reset=0 asserted mid-REQ → all outputs 0 immediately, no re-request after release.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: light encodings and pedestrian channel states shared with traffic_light_controller
package traffic_pkg;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN = 3'b001;
  typedef enum logic [1:0] {IDLE, REQ, SERVE, DONE} ped_state_t;
endpackage

// File: rtl/ped_channel.sv
// ped_channel: synchronise, debounce and latch one crosswalk button until the walk signal serves it
module ped_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SERVE_MIN = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_raw,
  input  logic ped_signal,
  output logic ped_button,
  output logic wait_lamp,
  output logic timeout
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SERVE_MIN + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SRV_MAX = SW'(SERVE_MIN);
  logic sync1, sync2, deb, deb_q, press, tmo_nx;
  logic [DW-1:0] deb_cnt;
  logic [AW-1:0] age, age_nx;
  logic [SW-1:0] srv, srv_nx;
  ped_state_t state, state_nx;
  assign press = deb & ~deb_q;
  assign ped_button = (state == REQ) || (state == SERVE);
  assign wait_lamp = state == REQ;
  // the level flips on the edge the run of differing samples reaches DEBOUNCE_CYCLES
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {sync1, sync2, deb, deb_q, timeout} <= '0;
      deb_cnt <= '0;
      age <= '0;
      srv <= '0;
      state <= IDLE;
    end else begin
      sync1 <= button_raw;
      sync2 <= sync1;
      deb_q <= deb;
      if (sync2 == deb) deb_cnt <= '0;
      else if (deb_cnt == DEB_MAX - 1'b1) begin
        deb <= sync2;
        deb_cnt <= '0;
      end else deb_cnt <= deb_cnt + 1'b1;
      state <= state_nx;
      age <= age_nx;
      srv <= srv_nx;
      timeout <= tmo_nx;
    end
  always_comb begin
    state_nx = state;
    age_nx = age;
    srv_nx = srv;
    tmo_nx = timeout;
    case (state)
      IDLE: if (press) begin
        state_nx = REQ;
        age_nx = '0;
      end
      REQ: begin
        age_nx = (age == AGE_MAX) ? age : age + 1'b1;
        tmo_nx = timeout | (age_nx == AGE_MAX);
        if (ped_signal) begin
          state_nx = SERVE;
          srv_nx = SW'(1);
        end
      end
      // a full SERVE_MIN run completes the request even if the signal has just dropped
      SERVE: if (srv == SRV_MAX) begin
        state_nx = DONE;
        tmo_nx = 1'b0;
      end else if (ped_signal) srv_nx = srv + 1'b1;
      else state_nx = REQ;
      DONE: if (!ped_signal) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: rtl/pedestrian_request_handler.sv
// pedestrian_request_handler: NS/EW crosswalk request front-end with walk-signal conflict monitor
module pedestrian_request_handler
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SERVE_MIN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       NS_button_raw,
  input  logic       EW_button_raw,
  input  logic       NS_pedestrian_Signal,
  input  logic       EW_pedestrian_Signal,
  input  logic [2:0] NS_direction,
  input  logic [2:0] EW_direction,
  output logic       NS_pedestrian_button,
  output logic       EW_pedestrian_button,
  output logic       NS_wait_lamp,
  output logic       EW_wait_lamp,
  output logic       NS_timeout,
  output logic       EW_timeout,
  output logic       conflict_err
);
  ped_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SERVE_MIN(SERVE_MIN)) u_ns (
    .clk(clk), .rst_n(reset), .button_raw(NS_button_raw), .ped_signal(NS_pedestrian_Signal),
    .ped_button(NS_pedestrian_button), .wait_lamp(NS_wait_lamp), .timeout(NS_timeout)
  );
  ped_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SERVE_MIN(SERVE_MIN)) u_ew (
    .clk(clk), .rst_n(reset), .button_raw(EW_button_raw), .ped_signal(EW_pedestrian_Signal),
    .ped_button(EW_pedestrian_button), .wait_lamp(EW_wait_lamp), .timeout(EW_timeout)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) conflict_err <= 1'b0;
    else if ((NS_pedestrian_Signal && NS_direction != RED) || (EW_pedestrian_Signal && EW_direction != RED))
      conflict_err <= 1'b1;
endmodule

// File: tb/tb_pedestrian_request_handler.sv
// tb_pedestrian_request_handler: directed checks of request latching, debounce, timeout, conflict and reset
module tb_pedestrian_request_handler;
  logic clk = 1'b0;
  logic reset, NS_button_raw, EW_button_raw, NS_pedestrian_Signal, EW_pedestrian_Signal;
  logic [2:0] NS_direction, EW_direction;
  logic NS_pedestrian_button, EW_pedestrian_button, NS_wait_lamp, EW_wait_lamp;
  logic NS_timeout, EW_timeout, conflict_err;
  logic [6:0] outs;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  // {NS_btn, EW_btn, NS_wait, EW_wait, NS_timeout, EW_timeout, conflict}
  assign outs = {NS_pedestrian_button, EW_pedestrian_button, NS_wait_lamp, EW_wait_lamp,
                 NS_timeout, EW_timeout, conflict_err};
  pedestrian_request_handler dut (
    .clk(clk), .reset(reset),
    .NS_button_raw(NS_button_raw), .EW_button_raw(EW_button_raw),
    .NS_pedestrian_Signal(NS_pedestrian_Signal), .EW_pedestrian_Signal(EW_pedestrian_Signal),
    .NS_direction(NS_direction), .EW_direction(EW_direction),
    .NS_pedestrian_button(NS_pedestrian_button), .EW_pedestrian_button(EW_pedestrian_button),
    .NS_wait_lamp(NS_wait_lamp), .EW_wait_lamp(EW_wait_lamp),
    .NS_timeout(NS_timeout), .EW_timeout(EW_timeout), .conflict_err(conflict_err)
  );
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b0;
    {NS_button_raw, EW_button_raw, NS_pedestrian_Signal, EW_pedestrian_Signal} = '0;
    NS_direction = 3'b100;
    EW_direction = 3'b100;
    for (int i = 0; i < 6; i++) begin
      NS_button_raw = i[0];
      EW_button_raw = ~i[0];
      tick(1);
    end
    chk("reset_hold", outs, 7'b0000000);
    NS_button_raw = 1'b0;
    EW_button_raw = 1'b0;
    reset = 1'b1;
    tick(100);
    chk("idle_100", outs, 7'b0000000);
    NS_button_raw = 1'b1;
    tick(6);
    chk("ns_edge6", outs, 7'b0000000);
    tick(1);
    chk("ns_edge7", outs, 7'b1010000);
    NS_button_raw = 1'b0;
    NS_pedestrian_Signal = 1'b1;
    tick(1);
    chk("ns_serve1", outs, 7'b1000000);
    tick(1);
    chk("ns_serve2", outs, 7'b1000000);
    NS_pedestrian_Signal = 1'b0;
    tick(1);
    chk("ns_done", outs, 7'b0000000);
    tick(15);
    chk("ns_idle", outs, 7'b0000000);
    for (int i = 0; i < 4; i++) begin
      NS_button_raw = ~i[0];
      tick(1);
    end
    NS_button_raw = 1'b0;
    tick(15);
    chk("bounce", outs, 7'b0000000);
    NS_button_raw = 1'b1;
    tick(3);
    NS_button_raw = 1'b0;
    tick(15);
    chk("pulse3", outs, 7'b0000000);
    NS_button_raw = 1'b1;
    tick(4);
    NS_button_raw = 1'b0;
    tick(2);
    chk("pulse4_e6", outs, 7'b0000000);
    tick(1);
    chk("pulse4_e7", outs, 7'b1010000);
    NS_pedestrian_Signal = 1'b1;
    tick(2);
    NS_pedestrian_Signal = 1'b0;
    tick(1);
    chk("pulse4_served", outs, 7'b0000000);
    tick(15);
    EW_button_raw = 1'b1;
    tick(7);
    chk("ew_req", outs, 7'b0101000);
    EW_button_raw = 1'b0;
    tick(63);
    chk("ew_age63", outs, 7'b0101000);
    tick(1);
    chk("ew_age64", outs, 7'b0101010);
    EW_pedestrian_Signal = 1'b1;
    tick(1);
    chk("ew_short_serve", outs, 7'b0100010);
    EW_pedestrian_Signal = 1'b0;
    tick(1);
    chk("ew_back_req", outs, 7'b0101010);
    EW_pedestrian_Signal = 1'b1;
    tick(2);
    chk("ew_serving", outs, 7'b0100010);
    EW_pedestrian_Signal = 1'b0;
    tick(1);
    chk("ew_done", outs, 7'b0000000);
    tick(5);
    NS_direction = 3'b001;
    NS_pedestrian_Signal = 1'b1;
    chk("conf_before", outs, 7'b0000000);
    tick(1);
    chk("conf_set", outs, 7'b0000001);
    NS_pedestrian_Signal = 1'b0;
    NS_direction = 3'b100;
    tick(3);
    chk("conf_sticky", outs, 7'b0000001);
    reset = 1'b0;
    #1;
    chk("conf_reset", outs, 7'b0000000);
    tick(1);
    reset = 1'b1;
    tick(3);
    EW_direction = 3'b010;
    tick(2);
    chk("ew_yellow_no_sig", outs, 7'b0000000);
    EW_direction = 3'b100;
    NS_button_raw = 1'b1;
    EW_button_raw = 1'b1;
    tick(6);
    chk("both_e6", outs, 7'b0000000);
    tick(1);
    chk("both_e7", outs, 7'b1111000);
    NS_button_raw = 1'b0;
    EW_button_raw = 1'b0;
    tick(2);
    chk("both_pending", outs, 7'b1111000);
    reset = 1'b0;
    #1;
    chk("mid_req_reset", outs, 7'b0000000);
    tick(2);
    chk("reset_held", outs, 7'b0000000);
    reset = 1'b1;
    tick(20);
    chk("no_rerequest", outs, 7'b0000000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
